// File: rtl/retire_trace.sv
// Retire trace buffer: captures write-back retire events into a FWFT FIFO,
// tags each with a sequence number, and counts events lost to a full buffer.
module retire_trace #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 5,
  parameter int FUNCT_WIDTH    = 3,
  parameter int OPCODE_WIDTH   = 7,
  parameter int PC_WIDTH       = 32,
  parameter int DEPTH          = 16,
  parameter int SEQ_WIDTH      = 16,
  parameter int FREEZE_ON_FULL = 0
) (
  input  logic                      rt_clk,
  input  logic                      rt_rst,
  input  logic                      rt_i_ce,
  input  logic                      rt_i_stall,
  input  logic                      rt_i_flush,
  input  logic [OPCODE_WIDTH-1:0]   rt_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]    rt_i_funct3,
  input  logic [AWIDTH-1:0]         rt_i_rd_addr,
  input  logic [DWIDTH-1:0]         rt_i_rd_data,
  input  logic [PC_WIDTH-1:0]       rt_i_next_pc,
  input  logic                      rt_i_arm,
  input  logic                      rt_i_disarm,
  input  logic                      rt_i_clear,
  input  logic                      rt_i_ready,
  output logic                      rt_o_valid,
  output logic [OPCODE_WIDTH-1:0]   rt_o_opcode,
  output logic [FUNCT_WIDTH-1:0]    rt_o_funct3,
  output logic [AWIDTH-1:0]         rt_o_rd_addr,
  output logic [DWIDTH-1:0]         rt_o_rd_data,
  output logic [PC_WIDTH-1:0]       rt_o_next_pc,
  output logic [SEQ_WIDTH-1:0]      rt_o_seq,
  output logic [$clog2(DEPTH):0]    rt_o_count,
  output logic [15:0]               rt_o_drop_cnt,
  output logic [1:0]                rt_o_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FROZEN = 2'b10
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [SEQ_WIDTH-1:0]    r_seq;
  logic [15:0]             r_drop_cnt;

  logic [OPCODE_WIDTH-1:0] r_mem_opcode  [DEPTH];
  logic [FUNCT_WIDTH-1:0]  r_mem_funct3  [DEPTH];
  logic [AWIDTH-1:0]       r_mem_rd_addr [DEPTH];
  logic [DWIDTH-1:0]       r_mem_rd_data [DEPTH];
  logic [PC_WIDTH-1:0]     r_mem_next_pc [DEPTH];
  logic [SEQ_WIDTH-1:0]    r_mem_seq     [DEPTH];

  logic w_event, w_capture, w_full, w_pop, w_push, w_drop;

  // Clear overrides any push or pop issued in the same cycle.
  assign w_event   = rt_i_ce & ~rt_i_stall & ~rt_i_flush;
  assign w_capture = w_event & (r_state == S_RUN);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = rt_o_valid & rt_i_ready & ~rt_i_clear;
  assign w_push    = w_capture & (~w_full | w_pop) & ~rt_i_clear;
  assign w_drop    = w_capture & w_full & ~w_pop & ~rt_i_clear;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rt_i_disarm)   w_state_nxt = S_IDLE;
        else if (rt_i_arm) w_state_nxt = S_RUN;
        else               w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (rt_i_disarm) w_state_nxt = S_IDLE;
        else if ((FREEZE_ON_FULL != 0) && w_push && !w_pop && (r_count == CW'(DEPTH - 1)))
          w_state_nxt = S_FROZEN;
        else w_state_nxt = S_RUN;
      end
      S_FROZEN: begin
        if (rt_i_disarm || rt_i_clear) w_state_nxt = S_IDLE;
        else                           w_state_nxt = S_FROZEN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rt_clk or posedge rt_rst) begin
    if (rt_rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (rt_i_clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_seq      <= '0;
        r_drop_cnt <= 16'h0000;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_capture) r_seq <= r_seq + SEQ_WIDTH'(1);
        if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge rt_clk) begin
    if (w_push) begin
      r_mem_opcode[r_wr_ptr]  <= rt_i_opcode;
      r_mem_funct3[r_wr_ptr]  <= rt_i_funct3;
      r_mem_rd_addr[r_wr_ptr] <= rt_i_rd_addr;
      r_mem_rd_data[r_wr_ptr] <= rt_i_rd_data;
      r_mem_next_pc[r_wr_ptr] <= rt_i_next_pc;
      r_mem_seq[r_wr_ptr]     <= r_seq;
    end
  end

  assign rt_o_valid    = (r_count != '0);
  assign rt_o_opcode   = rt_o_valid ? r_mem_opcode[r_rd_ptr]  : '0;
  assign rt_o_funct3   = rt_o_valid ? r_mem_funct3[r_rd_ptr]  : '0;
  assign rt_o_rd_addr  = rt_o_valid ? r_mem_rd_addr[r_rd_ptr] : '0;
  assign rt_o_rd_data  = rt_o_valid ? r_mem_rd_data[r_rd_ptr] : '0;
  assign rt_o_next_pc  = rt_o_valid ? r_mem_next_pc[r_rd_ptr] : '0;
  assign rt_o_seq      = rt_o_valid ? r_mem_seq[r_rd_ptr]     : '0;
  assign rt_o_count    = r_count;
  assign rt_o_drop_cnt = r_drop_cnt;
  assign rt_o_state    = r_state;

endmodule

// File: tb/tb_retire_trace.sv
// Directed bench for retire_trace: one drop-mode instance and one freeze-mode instance.
module tb_retire_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, stall, flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, next_pc;
  logic        arm, disarm, clear, ready;
  logic        f_arm, f_disarm, f_clear, f_ready;

  logic        valid, f_valid;
  logic [6:0]  o_opcode, f_opcode;
  logic [2:0]  o_funct3, f_funct3;
  logic [4:0]  o_rd_addr, f_rd_addr;
  logic [31:0] o_rd_data, f_rd_data, o_next_pc, f_next_pc;
  logic [15:0] o_seq, f_seq, drop_cnt, f_drop_cnt;
  logic [4:0]  count, f_count;
  logic [1:0]  state, f_state;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  retire_trace #(.FREEZE_ON_FULL(0)) u_dut (
    .rt_clk(clk), .rt_rst(rst), .rt_i_ce(ce), .rt_i_stall(stall), .rt_i_flush(flush),
    .rt_i_opcode(opcode), .rt_i_funct3(funct3), .rt_i_rd_addr(rd_addr),
    .rt_i_rd_data(rd_data), .rt_i_next_pc(next_pc), .rt_i_arm(arm),
    .rt_i_disarm(disarm), .rt_i_clear(clear), .rt_i_ready(ready),
    .rt_o_valid(valid), .rt_o_opcode(o_opcode), .rt_o_funct3(o_funct3),
    .rt_o_rd_addr(o_rd_addr), .rt_o_rd_data(o_rd_data), .rt_o_next_pc(o_next_pc),
    .rt_o_seq(o_seq), .rt_o_count(count), .rt_o_drop_cnt(drop_cnt), .rt_o_state(state)
  );

  retire_trace #(.FREEZE_ON_FULL(1)) u_frz (
    .rt_clk(clk), .rt_rst(rst), .rt_i_ce(ce), .rt_i_stall(stall), .rt_i_flush(flush),
    .rt_i_opcode(opcode), .rt_i_funct3(funct3), .rt_i_rd_addr(rd_addr),
    .rt_i_rd_data(rd_data), .rt_i_next_pc(next_pc), .rt_i_arm(f_arm),
    .rt_i_disarm(f_disarm), .rt_i_clear(f_clear), .rt_i_ready(f_ready),
    .rt_o_valid(f_valid), .rt_o_opcode(f_opcode), .rt_o_funct3(f_funct3),
    .rt_o_rd_addr(f_rd_addr), .rt_o_rd_data(f_rd_data), .rt_o_next_pc(f_next_pc),
    .rt_o_seq(f_seq), .rt_o_count(f_count), .rt_o_drop_cnt(f_drop_cnt), .rt_o_state(f_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_event(input int k);
    ce      = 1'b1;
    opcode  = 7'h33;
    funct3  = 3'(k % 8);
    rd_addr = 5'(k);
    rd_data = 32'h0000_000A + 32'(k) - 32'd1;
    next_pc = 32'h0000_0100 + 32'(4 * k);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0;
    opcode = 7'h00; funct3 = 3'd0; rd_addr = 5'd0; rd_data = 32'd0; next_pc = 32'd0;
    arm = 1'b0; disarm = 1'b0; clear = 1'b0; ready = 1'b0;
    f_arm = 1'b0; f_disarm = 1'b0; f_clear = 1'b0; f_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_state", state, 2'b00);
    check("reset_valid", valid, 1'b0);
    check("reset_count", count, 5'd0);
    check("reset_drop", drop_cnt, 16'd0);
    check("reset_head_zero", o_rd_data, 32'd0);

    // Arm with a concurrent event: that event must not be captured.
    arm = 1'b1; set_event(9);
    tick();
    arm = 1'b0; ce = 1'b0;
    check("arm_state", state, 2'b01);
    check("arm_event_ignored", count, 5'd0);

    // Three events with ready held high: head tracks the latest push.
    ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_event(k);
      tick();
      check("stream_count", count, 5'd1);
      check("stream_seq", o_seq, 16'(k - 1));
      check("stream_rd_addr", o_rd_addr, 5'(k));
      check("stream_rd_data", o_rd_data, 32'h9 + 32'(k));
      check("stream_next_pc", o_next_pc, 32'h100 + 32'(4 * k));
    end
    ce = 1'b0;
    tick();
    check("stream_drained", count, 5'd0);
    check("stream_valid_low", valid, 1'b0);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_state_run", state, 2'b01);

    // Stalled and flushed write-backs are not retire events.
    ready = 1'b0; set_event(4); stall = 1'b1;
    tick(); tick();
    stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; ce = 1'b0;
    check("stall_flush_count", count, 5'd0);
    set_event(5); tick(); ce = 1'b0;
    check("after_stall_seq", o_seq, 16'd0);
    check("after_stall_count", count, 5'd1);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_count", count, 5'd0);

    // Overfill drop-mode instance by two.
    for (int k = 0; k < 18; k++) begin
      set_event(k + 1);
      tick();
    end
    ce = 1'b0;
    check("overfill_count", count, 5'd16);
    check("overfill_drop", drop_cnt, 16'd2);
    check("overfill_state", state, 2'b01);
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_seq", o_seq, 16'(k));
      tick();
    end
    check("drain_empty", count, 5'd0);
    ready = 1'b0;
    set_event(1); tick(); ce = 1'b0;
    check("gap_seq", o_seq, 16'd18);

    // Fill to 16 (seq 19..33), then push and pop together at full.
    for (int k = 0; k < 15; k++) begin
      set_event(k + 2);
      tick();
    end
    ce = 1'b0;
    check("refill_count", count, 5'd16);
    set_event(3); rd_data = 32'h0000_DEAD; ready = 1'b1;
    tick();
    ce = 1'b0; ready = 1'b0;
    check("full_pushpop_count", count, 5'd16);
    check("full_pushpop_drop", drop_cnt, 16'd2);
    check("full_pushpop_head", o_seq, 16'd19);
    ready = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    ready = 1'b0;
    check("tail_data", o_rd_data, 32'h0000_DEAD);
    check("tail_seq", o_seq, 16'd34);
    check("tail_count", count, 5'd1);

    disarm = 1'b1; tick(); disarm = 1'b0;
    check("disarm_state", state, 2'b00);
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    check("arm_disarm_state", state, 2'b00);

    // Asynchronous reset in the middle of a burst.
    clear = 1'b1; tick(); clear = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_event(k + 1);
      tick();
    end
    ce = 1'b0;
    check("burst_count", count, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", valid, 1'b0);
    check("async_rst_count", count, 5'd0);
    check("async_rst_state", state, 2'b00);
    tick();
    rst = 1'b0;
    tick();

    // Freeze-on-full instance.
    f_arm = 1'b1; tick(); f_arm = 1'b0;
    check("frz_arm_state", f_state, 2'b01);
    for (int k = 0; k < 16; k++) begin
      set_event(k + 1);
      tick();
    end
    check("frz_state", f_state, 2'b10);
    check("frz_count", f_count, 5'd16);
    set_event(17); tick(); ce = 1'b0;
    check("frz_17th_count", f_count, 5'd16);
    check("frz_17th_drop", f_drop_cnt, 16'd0);
    f_arm = 1'b1; tick(); f_arm = 1'b0;
    check("frz_arm_ignored", f_state, 2'b10);
    f_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("frz_drain_seq", f_seq, 16'(k));
      tick();
    end
    f_ready = 1'b0;
    check("frz_drained", f_count, 5'd0);
    f_disarm = 1'b1; tick(); f_disarm = 1'b0;
    check("frz_disarm_state", f_state, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
